// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// Resolves conditional branches in EXE from the ALU flags and predicts them
// in ID from a table of 2-bit saturating counters (BHT). It redirects the PC
// on a taken prediction or a mispredict. A mispredict starts a flush pulse
// of FLUSH_CYC cycles, and the unit keeps branch and mispredict statistics.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   id_valid/id_is_bra  ID stage holds a valid conditional branch
//   id_pc, id_bra_pc    ID PC (indexes the BHT) and ID branch target
//   exe_valid, exe_pc   EXE stage valid and PC (selects the BHT entry to train)
//   eq/gt/le_bra        EXE branch-type decodes (one-hot or all zero)
//   equal/zero/less     ALU flags
//   exe_pred_taken      prediction that travelled down from ID
//   exe_bra_pc          EXE branch target
//   exe_fall_pc         EXE fall-through PC
//   pred_taken          ID prediction (combinational)
//   pcsrc, bra_pc       next-PC select and redirect target (combinational)
//   flush               kills younger instructions; registered
//   mispredict          single-cycle mispredict strobe (combinational)
//   bra_count           saturating count of resolved branches
//   miss_count          saturating count of mispredicts
//
// Flush FSM
//   state    | meaning
//   ST_IDLE  | normal operation; a mispredict loads r_fcnt and enters ST_FLUSH
//   ST_FLUSH | flush high; r_fcnt counts down, leaves at r_fcnt == 1
// ---------------------------------------------------------------------------
module branch_predict_unit #(
  parameter int PC_W      = 6,
  parameter int IDX_W     = 4,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_is_bra,
  input  logic [PC_W-1:0]  id_pc,
  input  logic [PC_W-1:0]  id_bra_pc,
  input  logic             exe_valid,
  input  logic [PC_W-1:0]  exe_pc,
  input  logic             eq_bra,
  input  logic             gt_bra,
  input  logic             le_bra,
  input  logic             equal,
  input  logic             zero,
  input  logic             less,
  input  logic             exe_pred_taken,
  input  logic [PC_W-1:0]  exe_bra_pc,
  input  logic [PC_W-1:0]  exe_fall_pc,
  output logic             pred_taken,
  output logic             pcsrc,
  output logic [PC_W-1:0]  bra_pc,
  output logic             flush,
  output logic             mispredict,
  output logic [CNT_W-1:0] bra_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t           r_state;
  logic [2:0]       r_fcnt;
  logic             r_flush;
  logic [1:0]       r_bht [DEPTH];
  logic [CNT_W-1:0] r_bra_count;
  logic [CNT_W-1:0] r_miss_count;

  logic             w_act_taken;
  logic             w_is_bra;
  logic             w_res_ok;
  logic             w_mispredict;
  logic             w_pred_taken;
  logic [IDX_W-1:0] w_ridx;
  logic [IDX_W-1:0] w_widx;
  logic [1:0]       w_wentry;

  // Upper PC bits do not take part in BHT indexing (entries alias).
  logic w_unused_pc;
  assign w_unused_pc = ^{id_pc[PC_W-1:IDX_W], exe_pc[PC_W-1:IDX_W]};

  // Resolution in EXE
  assign w_act_taken = (eq_bra & equal) | (gt_bra & ~(zero | less)) |
                       (le_bra & (zero | less));
  assign w_is_bra    = eq_bra | gt_bra | le_bra;
  // Wrong-path branches seen during a flush must not train or count.
  assign w_res_ok     = exe_valid & w_is_bra & ~r_flush & rst_n;
  assign w_mispredict = w_res_ok & (w_act_taken != exe_pred_taken);

  // Prediction in ID; reads the pre-update entry (no write bypass).
  assign w_ridx       = id_pc[IDX_W-1:0];
  assign w_widx       = exe_pc[IDX_W-1:0];
  assign w_wentry     = r_bht[w_widx];
  assign w_pred_taken = id_valid & id_is_bra & r_bht[w_ridx][1] & ~r_flush & rst_n;

  // EXE redirect wins over an ID prediction made in the same cycle.
  always_comb begin
    pcsrc  = 1'b0;
    bra_pc = id_bra_pc;
    if (!rst_n) begin
      pcsrc  = 1'b0;
      bra_pc = '0;
    end else if (w_mispredict) begin
      pcsrc  = 1'b1;
      bra_pc = w_act_taken ? exe_bra_pc : exe_fall_pc;
    end else if (w_pred_taken) begin
      pcsrc  = 1'b1;
      bra_pc = id_bra_pc;
    end
  end

  // BHT training
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_bht[i] <= 2'b01;
    end else if (w_res_ok) begin
      if (w_act_taken && (w_wentry != 2'b11))
        r_bht[w_widx] <= w_wentry + 2'b01;
      else if (!w_act_taken && (w_wentry != 2'b00))
        r_bht[w_widx] <= w_wentry - 2'b01;
    end
  end

  // Flush FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_fcnt  <= 3'd0;
      r_flush <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mispredict) begin
            r_state <= ST_FLUSH;
            r_fcnt  <= 3'(FLUSH_CYC);
            r_flush <= 1'b1;
          end
        end
        ST_FLUSH: begin
          r_fcnt <= r_fcnt - 3'd1;
          if (r_fcnt == 3'd1) begin
            r_state <= ST_IDLE;
            r_flush <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_fcnt  <= 3'd0;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  // Statistics, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bra_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_res_ok && (r_bra_count != '1))
        r_bra_count <= r_bra_count + 1'b1;
      if (w_mispredict && (r_miss_count != '1))
        r_miss_count <= r_miss_count + 1'b1;
    end
  end

  assign pred_taken = w_pred_taken;
  assign mispredict = w_mispredict;
  assign flush      = r_flush;
  assign bra_count  = r_bra_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  localparam int PC_W  = 6;
  localparam int IDX_W = 4;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid, id_is_bra;
  logic [PC_W-1:0]  id_pc, id_bra_pc;
  logic             exe_valid;
  logic [PC_W-1:0]  exe_pc;
  logic             eq_bra, gt_bra, le_bra;
  logic             equal, zero, less;
  logic             exe_pred_taken;
  logic [PC_W-1:0]  exe_bra_pc, exe_fall_pc;
  logic             pred_taken, pcsrc, flush, mispredict;
  logic [PC_W-1:0]  bra_pc;
  logic [CNT_W-1:0] bra_count, miss_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(
    .PC_W(PC_W), .IDX_W(IDX_W), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_is_bra(id_is_bra), .id_pc(id_pc), .id_bra_pc(id_bra_pc),
    .exe_valid(exe_valid), .exe_pc(exe_pc),
    .eq_bra(eq_bra), .gt_bra(gt_bra), .le_bra(le_bra),
    .equal(equal), .zero(zero), .less(less),
    .exe_pred_taken(exe_pred_taken), .exe_bra_pc(exe_bra_pc), .exe_fall_pc(exe_fall_pc),
    .pred_taken(pred_taken), .pcsrc(pcsrc), .bra_pc(bra_pc), .flush(flush),
    .mispredict(mispredict), .bra_count(bra_count), .miss_count(miss_count)
  );

  typedef struct {
    logic idv, idb; int idpc, idbpc;
    logic exv; int expc; logic eq, gt, le, eql, zr, ls, ept; int ebpc, efpc;
    logic e_pred, e_pcsrc; int e_brapc; logic e_mis, e_flush; int e_bc, e_mc;
  } vec_t;

  function automatic vec_t mk(logic idv, logic idb, int idpc, int idbpc,
                              logic exv, int expc, logic eq, logic gt, logic le,
                              logic eql, logic zr, logic ls, logic ept, int ebpc, int efpc,
                              logic e_pred, logic e_pcsrc, int e_brapc, logic e_mis,
                              logic e_flush, int e_bc, int e_mc);
    vec_t v;
    v.idv = idv; v.idb = idb; v.idpc = idpc; v.idbpc = idbpc;
    v.exv = exv; v.expc = expc; v.eq = eq; v.gt = gt; v.le = le;
    v.eql = eql; v.zr = zr; v.ls = ls; v.ept = ept; v.ebpc = ebpc; v.efpc = efpc;
    v.e_pred = e_pred; v.e_pcsrc = e_pcsrc; v.e_brapc = e_brapc; v.e_mis = e_mis;
    v.e_flush = e_flush; v.e_bc = e_bc; v.e_mc = e_mc;
    return v;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.idv; id_is_bra = v.idb; id_pc = PC_W'(v.idpc); id_bra_pc = PC_W'(v.idbpc);
    exe_valid = v.exv; exe_pc = PC_W'(v.expc);
    eq_bra = v.eq; gt_bra = v.gt; le_bra = v.le;
    equal = v.eql; zero = v.zr; less = v.ls; exe_pred_taken = v.ept;
    exe_bra_pc = PC_W'(v.ebpc); exe_fall_pc = PC_W'(v.efpc);
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " pred_taken"}, int'(pred_taken), int'(v.e_pred));
    chk({tag, " pcsrc"},      int'(pcsrc),      int'(v.e_pcsrc));
    chk({tag, " bra_pc"},     int'(bra_pc),     v.e_brapc);
    chk({tag, " mispredict"}, int'(mispredict), int'(v.e_mis));
    chk({tag, " flush"},      int'(flush),      int'(v.e_flush));
    chk({tag, " bra_count"},  int'(bra_count),  v.e_bc);
    chk({tag, " miss_count"}, int'(miss_count), v.e_mc);
  endtask

  vec_t tbl[25];
  vec_t idle5, mp5;

  initial begin
    // id pc / exe fields / expected {pred, pcsrc, bra_pc, mis, flush, bc, mc}
    tbl[0]  = mk(1,1,5,33, 0,0,0,0,0,0,0,0,0,0,0,   0,0,33,0,0, 0,0);  // cold start
    tbl[1]  = mk(0,0,5,33, 1,5,1,0,0,1,0,0,0,20,6,  0,1,20,1,0, 0,0);  // taken mispredict
    tbl[2]  = mk(1,1,5,33, 1,5,1,0,0,1,0,0,0,20,6,  0,0,33,0,1, 1,1);  // flush gating
    tbl[3]  = mk(1,1,5,33, 1,5,1,0,0,1,0,0,0,20,6,  0,0,33,0,1, 1,1);
    tbl[4]  = mk(1,1,5,44, 0,0,0,0,0,0,0,0,0,0,0,   1,1,44,0,0, 1,1);  // bht[5]=10
    tbl[5]  = mk(1,1,5,33, 1,5,0,0,1,0,0,0,1,40,9,  1,1,9,1,0,  1,1);  // not-taken mispredict
    tbl[6]  = mk(1,1,5,33, 0,0,0,0,0,0,0,0,0,0,0,   0,0,33,0,1, 2,2);
    tbl[7]  = mk(1,1,5,33, 0,0,0,0,0,0,0,0,0,0,0,   0,0,33,0,1, 2,2);
    tbl[8]  = mk(1,1,5,33, 0,0,0,0,0,0,0,0,0,0,0,   0,0,33,0,0, 2,2);  // bht[5]=01
    tbl[9]  = mk(1,1,3,33, 1,3,0,1,0,0,0,0,1,50,4,  0,0,33,0,0, 2,2);  // 01->10, old read
    tbl[10] = mk(1,1,3,33, 1,19,0,1,0,0,0,0,1,50,4, 1,1,33,0,0, 3,2);  // alias 19 -> 3
    tbl[11] = mk(1,1,3,33, 1,3,0,1,0,0,0,0,1,50,4,  1,1,33,0,0, 4,2);
    tbl[12] = mk(1,1,3,33, 1,3,0,1,0,0,0,0,1,50,4,  1,1,33,0,0, 5,2);
    tbl[13] = mk(1,1,3,33, 1,3,0,0,1,0,0,0,0,50,4,  1,1,33,0,0, 6,2);  // 11 -> 10
    tbl[14] = mk(1,1,3,33, 0,0,0,0,0,0,0,0,0,0,0,   1,1,33,0,0, 7,2);  // still taken
    tbl[15] = mk(1,1,7,33, 1,7,1,0,0,0,0,0,0,60,8,  0,0,33,0,0, 7,2);
    tbl[16] = mk(1,1,7,33, 1,7,1,0,0,0,0,0,0,60,8,  0,0,33,0,0, 8,2);
    tbl[17] = mk(1,1,7,33, 1,7,1,0,0,0,0,0,0,60,8,  0,0,33,0,0, 9,2);
    tbl[18] = mk(1,1,7,33, 1,7,1,0,0,0,0,0,0,60,8,  0,0,33,0,0, 10,2);
    tbl[19] = mk(1,1,7,33, 1,7,1,0,0,1,0,0,1,60,8,  0,0,33,0,0, 11,2); // 00 -> 01
    tbl[20] = mk(1,1,7,33, 0,0,0,0,0,0,0,0,0,0,0,   0,0,33,0,0, 12,2);
    tbl[21] = mk(1,1,9,33, 1,9,0,0,1,0,1,0,1,12,10, 0,0,33,0,0, 12,2); // le, zero -> taken
    tbl[22] = mk(1,1,9,33, 1,9,0,1,0,0,0,1,0,12,10, 1,1,33,0,0, 13,2); // gt, less -> not
    tbl[23] = mk(1,0,9,33, 0,9,1,0,0,1,0,0,0,12,10, 0,0,33,0,0, 14,2); // exe_valid=0
    tbl[24] = mk(1,1,9,33, 0,0,0,0,0,0,0,0,0,0,0,   0,0,33,0,0, 14,2);

    idle5 = mk(1,1,5,33, 0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    mp5   = mk(1,1,3,33, 1,5,1,0,0,1,0,0,0,20,6, 0,0,0,0,0,0,0);

    rst_n = 1'b0;
    drive(idle5);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i]);
      #1;
      check_vec($sformatf("vec%0d", i), tbl[i]);
      @(negedge clk);
    end

    // Reset asserted during the first flush cycle.
    drive(mp5);                       // bht[5]=01 so taken resolution mispredicts
    #1;
    chk("rst_seq mispredict", int'(mispredict), 1);
    chk("rst_seq redirect",   int'(bra_pc), 20);
    @(negedge clk);
    chk("rst_seq flush on", int'(flush), 1);
    rst_n = 1'b0;                     // inputs still present a mispredict
    #1;
    chk("rst_seq pcsrc in reset",  int'(pcsrc), 0);
    chk("rst_seq bra_pc in reset", int'(bra_pc), 0);
    chk("rst_seq mis in reset",    int'(mispredict), 0);
    chk("rst_seq pred in reset",   int'(pred_taken), 0);
    @(negedge clk);
    chk("rst_seq flush cleared", int'(flush), 0);
    chk("rst_seq bra_count",     int'(bra_count), 0);
    chk("rst_seq miss_count",    int'(miss_count), 0);
    rst_n = 1'b1;
    drive(idle5);
    id_pc = PC_W'(3);                 // was 10 before reset
    #1;
    chk("rst_seq bht3 reset", int'(pred_taken), 0);
    chk("rst_seq pcsrc",      int'(pcsrc), 0);
    id_pc = PC_W'(9);
    #1;
    chk("rst_seq bht9 reset", int'(pred_taken), 0);
    @(negedge clk);
    chk("rst_seq flush idle", int'(flush), 0);
    chk("rst_seq bc idle",    int'(bra_count), 0);
    // Cold-start mispredict after release still flushes for FLUSH_CYC cycles.
    drive(mp5);
    #1;
    chk("post_rst mispredict", int'(mispredict), 1);
    @(negedge clk);
    drive(idle5);
    #1;
    chk("post_rst flush c1", int'(flush), 1);
    @(negedge clk);
    chk("post_rst flush c2", int'(flush), 1);
    @(negedge clk);
    chk("post_rst flush end", int'(flush), 0);
    chk("post_rst miss_count", int'(miss_count), 1);
    chk("post_rst bra_count",  int'(bra_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised branch unit that extends the simple eq/gt/le branch resolver.
- Resolves conditional branches in EXE using the ALU flags (equal, zero, less).
- Predicts branches in ID from a table of 2-bit saturating counters (BHT) and redirects the PC (pcsrc, bra_pc).
- On a misprediction it drives a multi-cycle pipeline flush and counts branch and mispredict events.

Parameters:
- PC_W, 6, width of all PC and target buses.
- IDX_W, 4, BHT index width; BHT depth = 2**IDX_W entries.
- FLUSH_CYC, 2, flush pulse length in cycles after a mispredict (1..7).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_is_bra  in  1  ID instruction is a conditional branch.
- id_pc  in  PC_W  PC of the ID instruction.
- id_bra_pc  in  PC_W  branch target computed in ID.
- exe_valid  in  1  EXE stage holds a valid instruction.
- exe_pc  in  PC_W  PC of the EXE instruction.
- eq_bra, gt_bra, le_bra  in  1 each  branch-type decodes (one-hot or all 0).
- equal, zero, less  in  1 each  ALU flags.
- exe_pred_taken  in  1  prediction carried down the pipe from ID.
- exe_bra_pc  in  PC_W  branch target in EXE.
- exe_fall_pc  in  PC_W  fall-through PC (exe_pc+1) in EXE.
- pred_taken  out  1  ID prediction.
- pcsrc  out  1  select bra_pc as next PC this cycle.
- bra_pc  out  PC_W  redirect PC.
- flush  out  1  kill IF/ID/EXE younger instructions.
- mispredict  out  1  single-cycle mispredict strobe (combinational).
- bra_count  out  CNT_W  resolved-branch count.
- miss_count  out  CNT_W  mispredict count.

Behaviour:
- Resolution (combinational in EXE):
  - act_taken = (eq_bra & equal) | (gt_bra & ~(zero|less)) | (le_bra & (zero|less)).
  - is_bra = eq_bra|gt_bra|le_bra.
  - res_ok = exe_valid & is_bra & ~flush & rst_n.
  - mispredict = res_ok & (act_taken != exe_pred_taken).
- Prediction (combinational in ID):
  - idx = id_pc[IDX_W-1:0].
  - pred_taken = id_valid & id_is_bra & bht[idx][1] & ~flush & rst_n.
- Redirect priority (EXE first):
  - If mispredict: pcsrc=1; bra_pc = act_taken ? exe_bra_pc : exe_fall_pc.
  - Else if pred_taken: pcsrc=1; bra_pc = id_bra_pc.
  - Else: pcsrc=0, bra_pc=id_bra_pc (don't-care).
  - While rst_n=0: pcsrc=0, bra_pc=0.
- BHT update (registered):
  - On every clk with res_ok, entry exe_pc[IDX_W-1:0] moves +1 if act_taken, -1 otherwise.
  - Saturates at 3 and 0; never wraps.
  - Same-cycle ID read of the entry being written returns the old value (no bypass).
  - Reads of other entries are unaffected.
- Flush FSM, states IDLE / FLUSH with down-counter fcnt (3 bits):
  - IDLE: mispredict -> load fcnt=FLUSH_CYC, go to FLUSH.
  - FLUSH: flush=1; fcnt decrements each cycle; at fcnt==1 return to IDLE.
  - flush is therefore high for exactly FLUSH_CYC cycles, starting the cycle after mispredict.
  - A mispredict cannot occur in FLUSH because res_ok is gated by ~flush; wrong-path EXE branches neither update the BHT nor count.
  - pred_taken is forced 0 during FLUSH.
- Counters:
  - bra_count += 1 on res_ok.
  - miss_count += 1 on mispredict.
  - Both saturate at all-ones.
- Reset, synchronous, also when asserted mid-flush or mid-operation: next edge gives
  - every BHT entry = 2'b01 (weakly not-taken);
  - state=IDLE, fcnt=0, flush=0;
  - bra_count=0, miss_count=0.
  - The first cycle after release behaves as cold start.
- Latency:
  - pcsrc/bra_pc/mispredict/pred_taken: 0 cycles (combinational).
  - BHT/counter update visible 1 cycle after the resolving edge.
  - flush: asserted 1 cycle after mispredict.

Test Plan:
- Cold start: reset, id_pc=5, id_is_bra=1, id_valid=1 -> pred_taken=0, pcsrc=0 (entry 01); bra_count=miss_count=0, flush=0.
- Taken mispredict: exe_pc=5, eq_bra=1, equal=1, exe_pred_taken=0, exe_bra_pc=20, exe_fall_pc=6 -> mispredict=1, pcsrc=1, bra_pc=20; flush high for exactly 2 cycles; miss_count=1, bra_count=1; bht[5]=10 so next id_pc=5 gives pred_taken=1, bra_pc=id_bra_pc.
- Not-taken mispredict: le_bra=1, zero=0, less=0, exe_pred_taken=1, exe_fall_pc=9 -> bra_pc=9, pcsrc=1; same cycle id_valid with pred_taken=1 is overridden by EXE.
- Saturation: 4 taken resolutions on pc=3 then 1 not-taken -> counter 01->10->11->11->11->10, prediction stays taken; 4 not-taken from 01 bottoms at 00; exe_pc=19 aliases to idx 3.
- Flush gating: during flush, present exe_valid=1, eq_bra=1, equal=1, exe_pred_taken=0 -> mispredict=0, no BHT or counter change, pred_taken=0.
- Reset mid-flush: assert rst_n=0 during the first flush cycle -> next edge flush=0, counters 0, all entries 01; pcsrc=0 while in reset.
